poly_sub_ctrl: RTL

Sequencer that computes the coefficient-wise modular difference z[i] = (a[i] − b[i]) mod Q for one full polynomial of N coefficients. It reads from two coefficient banks and writes the results to a destination bank. Between those it drives the shared modular add/sub core. It sits beside the NTT butterfly datapath and is launched by the top-level NTT controller through a start/done handshake.

---
 rtl/ntt_pkg.sv | 17 +
 rtl/mod_addsub_core.sv | 43 ++++
 rtl/poly_sub_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/ntt_pkg.sv
// Shared NTT-side definitions: default polynomial/modulus parameters and the
// sequencer state encoding used by poly_sub_ctrl.
package ntt_pkg;

    localparam int unsigned NTT_DATA_WIDTH = 12;
    localparam int unsigned NTT_ADDR_WIDTH = 8;
    localparam int unsigned NTT_N          = 256;
    localparam int unsigned NTT_Q          = 3329;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/mod_addsub_core.sv
// Combinational modular subtract (and add, when POLY_SUB_ADD_EN is defined).
// Operands are assumed < Q; the result is then in [0, Q-1].
module mod_addsub_core #(
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned Q          = 3329
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
`ifdef POLY_SUB_ADD_EN
    input  logic                  op,
`endif
    output logic [DATA_WIDTH-1:0] z
);

    localparam logic [DATA_WIDTH:0] QW = (DATA_WIDTH+1)'(Q);

    logic [DATA_WIDTH:0]   diff;
    logic [DATA_WIDTH-1:0] res;
`ifdef POLY_SUB_ADD_EN
    logic [DATA_WIDTH:0]   sum;
`endif

    always_comb begin
        // The extra top bit doubles as the borrow flag
        diff = {1'b0, a} - {1'b0, b};
        if (diff[DATA_WIDTH]) begin
            diff = diff + QW;
        end
        res = diff[DATA_WIDTH-1:0];
`ifdef POLY_SUB_ADD_EN
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= QW) begin
            sum = sum - QW;
        end
        if (op) begin
            res = sum[DATA_WIDTH-1:0];
        end
`endif
    end

    assign z = res;

endmodule

// File: rtl/poly_sub_ctrl.sv
// Coefficient-wise modular difference sequencer: reads banks A/B, writes
// (a-b) mod Q to the destination bank. POLY_SUB_ADD_EN adds the op port (add).
module poly_sub_ctrl
    import ntt_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = NTT_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = NTT_ADDR_WIDTH,
    parameter int unsigned N          = NTT_N,
    parameter int unsigned Q          = NTT_Q
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
`ifdef POLY_SUB_ADD_EN
    input  logic                  op,
`endif
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] a_dout,
    input  logic [DATA_WIDTH-1:0] b_dout,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N - 1);

    state_t                state;
    logic                  v1;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] core_z;
`ifdef POLY_SUB_ADD_EN
    logic                  op_q;
`endif

    mod_addsub_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .Q          (Q)
    ) u_core (
        .a  (a_dout),
        .b  (b_dout),
`ifdef POLY_SUB_ADD_EN
        .op (op_q),
`endif
        .z  (core_z)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            rd_en   <= 1'b0;
            rd_addr <= '0;
`ifdef POLY_SUB_ADD_EN
            op_q    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state   <= RUN;
                        busy    <= 1'b1;
                        rd_en   <= 1'b1;
                        rd_addr <= '0;
`ifdef POLY_SUB_ADD_EN
                        op_q    <= op;
`endif
                    end
                end
                RUN: begin
                    if (rd_addr == LAST_ADDR) begin
                        state <= DRAIN;
                        rd_en <= 1'b0;
                    end else begin
                        rd_addr <= rd_addr + 1'b1;
                    end
                end
                DRAIN: begin
                    // Stage 1 empty means stage 2 holds the final write this cycle
                    if (!v1) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    rd_addr <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1      <= 1'b0;
            addr1   <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            v1    <= rd_en;
            addr1 <= rd_addr;
            wr_en <= v1;
            if (v1) begin
                wr_addr <= addr1;
                wr_data <= core_z;
            end
        end
    end

endmodule
